exec_alu_stage: RTL and testbench

- Execute stage of the Y86-64 datapath, directly downstream of decode and upstream of memory.
- Computes valE using an adder/logic unit and the existing 64-bit arithmetic right shifter, which is instantiated inside this block.
- Owns the condition-code register (ZF, SF, OF) and evaluates Cnd for cmovXX and jXX.
- Result is held in a one-entry output register with a valid/ready handshake on both sides.

---
 rtl/exec_alu_stage_if.sv | 28 ++
 rtl/exec_alu_stage.sv | 144 ++++++++++++++
 tb/tb_exec_alu_stage.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_alu_stage_if.sv
// Handshake and data bundle between decode, the execute stage and memory.
// The stage itself takes the slave view; decode/memory (or a bench) take master.
interface exec_alu_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_icode;
  logic [3:0]  in_ifun;
  logic [63:0] in_valA;
  logic [63:0] in_valB;
  logic [63:0] in_valC;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_valE;
  logic        out_cnd;
  logic [3:0]  out_icode;
  logic        out_err;
  logic [2:0]  cc_out;

  modport master (
    output in_valid, in_icode, in_ifun, in_valA, in_valB, in_valC, out_ready,
    input  in_ready, out_valid, out_valE, out_cnd, out_icode, out_err, cc_out
  );

  modport slave (
    input  in_valid, in_icode, in_ifun, in_valA, in_valB, in_valC, out_ready,
    output in_ready, out_valid, out_valE, out_cnd, out_icode, out_err, cc_out
  );
endinterface

// File: rtl/exec_alu_stage.sv
// Y86-64 execute stage: computes valE, owns the {ZF,SF,OF} condition codes,
// evaluates Cnd for cmovXX/jXX and holds the result in a one-entry output
// register with valid/ready on both sides.

// 64-bit arithmetic right shifter used by OPq sar.
module exec_sar64 (
  input  logic [63:0] value_i,
  input  logic [5:0]  amount_i,
  output logic [63:0] result_o
);
  // Sign-filling shift of the operand by a 0..63 bit amount.
  always_comb begin
    result_o = $signed(value_i) >>> amount_i;
  end
endmodule

module exec_alu_stage #(
  parameter int         W        = 64,
  parameter logic [2:0] RESET_CC = 3'b100
) (
  input logic             clk,
  input logic             rst,
  exec_alu_stage_if.slave bus
);
  typedef enum logic {EMPTY, FULL} state_t;

  state_t       state_q;
  logic [W-1:0] outValE_q;
  logic         outCnd_q;
  logic [3:0]   outIcode_q;
  logic         outErr_q;
  logic [2:0]   cc_q;

  logic [W-1:0] valE_d;
  logic         err_d;
  logic         cnd_d;
  logic         condTrue;
  logic         ofNew;
  logic [2:0]   ccNew;
  logic         ccWrite;
  logic         isOpq;
  logic         inReady;
  logic         accept;
  logic         signLt;
  logic [W-1:0] shiftResult;

  exec_sar64 u_sar (
    .value_i  (bus.in_valB),
    .amount_i (bus.in_valA[5:0]),
    .result_o (shiftResult)
  );

  // A new instruction fits when the output slot is empty or being drained now.
  always_comb begin
    inReady = (state_q == EMPTY) || bus.out_ready;
    accept  = bus.in_valid && inReady;
    isOpq   = (bus.in_icode == 4'h6);
  end

  // valE selection by icode; OPq with an unknown ifun produces 0 and flags err.
  always_comb begin
    valE_d = '0;
    err_d  = 1'b0;
    case (bus.in_icode)
      4'h2:       valE_d = bus.in_valA;
      4'h3:       valE_d = bus.in_valC;
      4'h4, 4'h5: valE_d = bus.in_valB + bus.in_valC;
      4'h6: begin
        case (bus.in_ifun)
          4'h0:    valE_d = bus.in_valB + bus.in_valA;
          4'h1:    valE_d = bus.in_valB - bus.in_valA;
          4'h2:    valE_d = bus.in_valB & bus.in_valA;
          4'h3:    valE_d = bus.in_valB ^ bus.in_valA;
          4'h4:    valE_d = shiftResult;
          default: err_d  = 1'b1;
        endcase
      end
      4'h8, 4'hA: valE_d = bus.in_valB - W'(8);
      4'h9, 4'hB: valE_d = bus.in_valB + W'(8);
      default:    valE_d = '0;
    endcase
  end

  // New condition codes from the OPq result; only add/sub can overflow.
  always_comb begin
    ofNew = 1'b0;
    if (bus.in_ifun == 4'h0) begin
      ofNew = (bus.in_valA[W-1] == bus.in_valB[W-1]) && (valE_d[W-1] != bus.in_valB[W-1]);
    end else if (bus.in_ifun == 4'h1) begin
      ofNew = (bus.in_valA[W-1] != bus.in_valB[W-1]) && (valE_d[W-1] != bus.in_valB[W-1]);
    end
    ccNew   = {(valE_d == '0), valE_d[W-1], ofNew};
    ccWrite = accept && isOpq && !err_d;
  end

  // Branch/move condition from the codes as they stand before this edge.
  always_comb begin
    signLt = cc_q[1] ^ cc_q[0];
    case (bus.in_ifun)
      4'h0:    condTrue = 1'b1;
      4'h1:    condTrue = signLt | cc_q[2];
      4'h2:    condTrue = signLt;
      4'h3:    condTrue = cc_q[2];
      4'h4:    condTrue = !cc_q[2];
      4'h5:    condTrue = !signLt;
      4'h6:    condTrue = !signLt && !cc_q[2];
      default: condTrue = 1'b0;
    endcase
    cnd_d = condTrue && ((bus.in_icode == 4'h2) || (bus.in_icode == 4'h7));
  end

  // EMPTY/FULL control with the output register and condition codes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      outValE_q  <= '0;
      outCnd_q   <= 1'b0;
      outIcode_q <= 4'h0;
      outErr_q   <= 1'b0;
      cc_q       <= RESET_CC;
    end else begin
      if (accept) begin
        state_q    <= FULL;
        outValE_q  <= valE_d;
        outCnd_q   <= cnd_d;
        outIcode_q <= bus.in_icode;
        outErr_q   <= err_d;
      end else if ((state_q == FULL) && bus.out_ready) begin
        state_q <= EMPTY;
      end
      if (ccWrite) begin
        cc_q <= ccNew;
      end
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_valE  = outValE_q;
  assign bus.out_cnd   = outCnd_q;
  assign bus.out_icode = outIcode_q;
  assign bus.out_err   = outErr_q;
  assign bus.cc_out    = cc_q;
endmodule

// File: tb/tb_exec_alu_stage.sv
// Scoreboarded bench for the execute stage: a behavioural model predicts each
// result when it is issued, and the entry is checked when it appears at the output.
module tb_exec_alu_stage;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  exec_alu_stage_if bus ();

  exec_alu_stage #(.W(64), .RESET_CC(3'b100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [63:0] valE;
    logic        cnd;
    logic [3:0]  icode;
    logic        err;
    logic [2:0]  cc;
  } expEntry_t;

  expEntry_t  sb[$];
  expEntry_t  exp;
  logic [2:0] modelCc;
  int         errors;
  int         checks;
  logic [73:0] saved;

  wire [73:0] obsVec = {bus.out_valid, bus.out_valE, bus.out_cnd, bus.out_icode, bus.out_err, bus.cc_out};
  localparam logic [73:0] RESET_VEC = {1'b0, 64'd0, 1'b0, 4'h0, 1'b0, 3'b100};

  // Reference behaviour, written with wide signed arithmetic for overflow.
  function automatic expEntry_t model(input logic [3:0] icode, input logic [3:0] ifun,
                                      input logic [63:0] a, input logic [63:0] b,
                                      input logic [63:0] c, input logic [2:0] ccIn);
    expEntry_t e;
    logic [64:0] wide;
    logic of;
    logic zf, sf, ofIn, lt, cond;
    e = '0;
    e.icode = icode;
    e.cc = ccIn;
    of = 1'b0;
    case (icode)
      4'h2: e.valE = a;
      4'h3: e.valE = c;
      4'h4, 4'h5: e.valE = b + c;
      4'h6: begin
        case (ifun)
          4'h0: begin wide = {b[63], b} + {a[63], a}; e.valE = wide[63:0]; of = wide[64] ^ wide[63]; end
          4'h1: begin wide = {b[63], b} - {a[63], a}; e.valE = wide[63:0]; of = wide[64] ^ wide[63]; end
          4'h2: e.valE = b & a;
          4'h3: e.valE = b ^ a;
          4'h4: e.valE = 64'($signed(b) >>> a[5:0]);
          default: e.err = 1'b1;
        endcase
        if (!e.err) e.cc = {e.valE == 64'd0, e.valE[63], of};
      end
      4'h8, 4'hA: e.valE = b - 64'd8;
      4'h9, 4'hB: e.valE = b + 64'd8;
      default: e.valE = 64'd0;
    endcase
    zf = ccIn[2]; sf = ccIn[1]; ofIn = ccIn[0];
    lt = sf ^ ofIn;
    case (ifun)
      4'h0: cond = 1'b1;
      4'h1: cond = lt | zf;
      4'h2: cond = lt;
      4'h3: cond = zf;
      4'h4: cond = ~zf;
      4'h5: cond = ~lt;
      4'h6: cond = ~lt & ~zf;
      default: cond = 1'b0;
    endcase
    e.cnd = (icode == 4'h2 || icode == 4'h7) ? cond : 1'b0;
    return e;
  endfunction

  // Presents one instruction that will be accepted at the next edge and records its expectation.
  task automatic issue(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    bus.in_valid = 1'b1;
    bus.in_icode = icode;
    bus.in_ifun  = ifun;
    bus.in_valA  = a;
    bus.in_valB  = b;
    bus.in_valC  = c;
    sb.push_back(model(icode, ifun, a, b, c, modelCc));
    modelCc = sb[$].cc;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_icode  = 4'h6;
    bus.in_ifun   = 4'h0;
    bus.in_valA   = 64'd1;
    bus.in_valB   = 64'd2;
    bus.in_valC   = 64'd0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    modelCc = 3'b100;
    sb.delete();
    checks++;
    if (obsVec !== RESET_VEC) begin
      errors++;
      $display("[TB] FAIL reset_state: got %h want %h", obsVec, RESET_VEC);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_add_zero();
    issue(4'h6, 4'h0, 64'd5, -64'sd5, 64'd0);
    exp = sb.pop_front();
    checks++;
    if (obsVec !== {1'b1, exp} || exp.cc !== 3'b100) begin
      errors++;
      $display("[TB] FAIL add_zero: got %h want %h", obsVec, {1'b1, exp});
    end
  endtask

  task automatic test_overflow();
    issue(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
    exp = sb.pop_front();
    checks++;
    if (obsVec !== {1'b1, exp} || bus.out_valE !== 64'hFFFF_FFFF_FFFF_FFFE || bus.cc_out !== 3'b011) begin
      errors++;
      $display("[TB] FAIL add_overflow: got %h want %h", obsVec, {1'b1, exp});
    end
    issue(4'h7, 4'h2, 64'd0, 64'd0, 64'h100);
    exp = sb.pop_front();
    checks++;
    if (obsVec !== {1'b1, exp} || bus.out_cnd !== 1'b0) begin
      errors++;
      $display("[TB] FAIL jl_after_overflow: got %h want %h", obsVec, {1'b1, exp});
    end
  endtask

  task automatic test_shift();
    issue(4'h6, 4'h4, 64'h43, 64'h8000_0000_0000_0000, 64'd0);
    exp = sb.pop_front();
    checks++;
    if (obsVec !== {1'b1, exp} || bus.out_valE !== 64'hF000_0000_0000_0000 || bus.cc_out !== 3'b010) begin
      errors++;
      $display("[TB] FAIL sar: got %h want %h", obsVec, {1'b1, exp});
    end
  endtask

  task automatic test_illegal();
    issue(4'h6, 4'h1, 64'd1, 64'd0, 64'd0);
    exp = sb.pop_front();
    checks++;
    if (obsVec !== {1'b1, exp} || bus.cc_out !== 3'b010) begin
      errors++;
      $display("[TB] FAIL sub_negative: got %h want %h", obsVec, {1'b1, exp});
    end
    for (int f = 5; f < 8; f++) begin
      issue(4'h6, 4'(f), {$urandom, $urandom}, {$urandom, $urandom}, 64'd7);
      exp = sb.pop_front();
      checks++;
      if (obsVec !== {1'b1, exp} || bus.out_err !== 1'b1 || bus.cc_out !== 3'b010) begin
        errors++;
        $display("[TB] FAIL illegal_ifun%0d: got %h want %h", f, obsVec, {1'b1, exp});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ic;
    logic [3:0] fn;
    for (int i = 0; i < 40; i++) begin
      ic = (i % 3 == 0) ? 4'h6 : 4'($urandom_range(0, 15));
      fn = (ic == 4'h6) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(0, 7));
      issue(ic, fn, (i % 5 == 0) ? 64'd0 : {$urandom, $urandom},
            (i % 7 == 0) ? 64'd0 : {$urandom, $urandom}, {$urandom, $urandom});
      exp = sb.pop_front();
      checks++;
      if (obsVec !== {1'b1, exp}) begin
        errors++;
        $display("[TB] FAIL mix_%0d icode=%h ifun=%h: got %h want %h", i, ic, fn, obsVec, {1'b1, exp});
      end
    end
  endtask

  task automatic test_stall();
    logic [63:0] opA[3];
    logic [63:0] opB[3];
    logic [3:0]  fns[3];
    opA[0] = 64'd3;  opB[0] = 64'd3;  fns[0] = 4'h1;
    opA[1] = 64'd0;  opB[1] = 64'd9;  fns[1] = 4'h4;
    opA[2] = 64'hF0; opB[2] = 64'hFF; fns[2] = 4'h2;
    issue(4'h3, 4'h0, 64'd0, 64'd0, 64'hDEAD_BEEF);
    exp = sb.pop_front();
    checks++;
    if (obsVec !== {1'b1, exp}) begin
      errors++;
      $display("[TB] FAIL stall_fill: got %h want %h", obsVec, {1'b1, exp});
    end
    saved = obsVec;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.in_icode = 4'h6;
      bus.in_ifun  = fns[k];
      bus.in_valA  = opA[k];
      bus.in_valB  = opB[k];
      bus.in_valC  = 64'd0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_in_ready_%0d: got %b want 0", k, bus.in_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (obsVec !== saved) begin
        errors++;
        $display("[TB] FAIL stall_hold_%0d: got %h want %h", k, obsVec, saved);
      end
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      issue(4'h6, fns[k], opA[k], opB[k], 64'd0);
      exp = sb.pop_front();
      checks++;
      if (obsVec !== {1'b1, exp}) begin
        errors++;
        $display("[TB] FAIL drain_%0d: got %h want %h", k, obsVec, {1'b1, exp});
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drain_empty: got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_stall();
    issue(4'h6, 4'h1, 64'd10, 64'd3, 64'd0);
    exp = sb.pop_front();
    checks++;
    if (obsVec !== {1'b1, exp}) begin
      errors++;
      $display("[TB] FAIL pre_reset_fill: got %h want %h", obsVec, {1'b1, exp});
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    modelCc = 3'b100;
    checks++;
    if (obsVec !== RESET_VEC) begin
      errors++;
      $display("[TB] FAIL reset_mid_stall: got %h want %h", obsVec, RESET_VEC);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_mid_stall_in_ready: got %b want 1", bus.in_ready);
    end
    bus.out_ready = 1'b1;
  endtask

  // Bounds the whole run in case the stage or bench locks up.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Runs every scenario in order and prints the summary.
  initial begin
    errors = 0;
    checks = 0;
    modelCc = 3'b100;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_icode = 4'h0;
    bus.in_ifun  = 4'h0;
    bus.in_valA  = 64'd0;
    bus.in_valB  = 64'd0;
    bus.in_valC  = 64'd0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_add_zero();
    test_overflow();
    test_shift();
    test_illegal();
    test_back_to_back();
    test_stall();
    test_reset_stall();
    test_add_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
